// File: rtl/temp_display_fmt_pkg.sv
// Shared types and constants for the temperature display formatter.
package temp_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CONV,
        DONE
    } state_e;

    // Four glyph codes, index 3 is the leftmost digit.
    typedef logic [3:0][4:0] digits_t;

    localparam logic [1:0] MODE_CELSIUS = 2'b00;
    localparam logic [1:0] MODE_ID      = 2'b01;
    localparam logic [1:0] MODE_RAW     = 2'b10;
    localparam logic [1:0] MODE_AUX     = 2'b11;

    // Codes 0x00..0x0F are the hex glyphs; these sit above that range.
    localparam logic [4:0] GLYPH_BLANK = 5'h10;
    localparam logic [4:0] GLYPH_MINUS = 5'h11;

    localparam digits_t SAT_DIGITS  = {GLYPH_MINUS, 5'd9, 5'd9, 5'd9};
    localparam digits_t ZERO_DIGITS = {GLYPH_BLANK, GLYPH_BLANK, 5'd0, 5'd0};

    // Lays out sign, BCD integer part and tenths as "hTU.t" / "-TU.t".
    function automatic digits_t fmt_celsius(
        input logic        neg,
        input logic [11:0] bcd,
        input logic [3:0]  tenths
    );
        digits_t    d;
        logic [4:0] hund;
        logic [4:0] tens;
        hund = {1'b0, bcd[11:8]};
        tens = {1'b0, bcd[7:4]};
        d[1] = {1'b0, bcd[3:0]};
        d[0] = {1'b0, tenths};
        if (neg) begin
            d[3] = GLYPH_MINUS;
            d[2] = (tens == 5'd0) ? GLYPH_BLANK : tens;
            if (hund != 5'd0) begin
                d = SAT_DIGITS;
            end
        end else begin
            d[3] = (hund == 5'd0) ? GLYPH_BLANK : hund;
            d[2] = (hund == 5'd0 && tens == 5'd0) ? GLYPH_BLANK : tens;
        end
        return d;
    endfunction

endpackage

// File: rtl/temp_display_fmt_seg7_glyph.sv
// Glyph code to active-low 7-segment pattern, seg[0]=a .. seg[6]=g.
module seg7_glyph
    import temp_disp_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (code)
            5'h00: seg = 7'h40;
            5'h01: seg = 7'h79;
            5'h02: seg = 7'h24;
            5'h03: seg = 7'h30;
            5'h04: seg = 7'h19;
            5'h05: seg = 7'h12;
            5'h06: seg = 7'h02;
            5'h07: seg = 7'h78;
            5'h08: seg = 7'h00;
            5'h09: seg = 7'h10;
            5'h0A: seg = 7'h08;
            5'h0B: seg = 7'h03;
            5'h0C: seg = 7'h46;
            5'h0D: seg = 7'h21;
            5'h0E: seg = 7'h06;
            5'h0F: seg = 7'h0E;
            GLYPH_MINUS: seg = 7'h3F;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/temp_display_fmt.sv
// Converts the sensor temperature word to signed decimal and drives a 4-digit display.
// Optional: define MINMAX_HOLD_EN to show the running maximum on sw=11.
module temp_display_fmt
    import temp_disp_pkg::*;
#(
    parameter int STABLE_CYCLES = 64,
    parameter int REFRESH_DIV   = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] temp_raw,
    input  logic [7:0]  id,
    input  logic [1:0]  sw,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        busy
);

    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam int RCW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [SCW-1:0] STAB_MAX = SCW'(STABLE_CYCLES);
    localparam logic [RCW-1:0] REF_LAST = RCW'(REFRESH_DIV - 1);

    logic [15:0]    raw_q, raw_d;
    logic [SCW-1:0] stab_q, stab_d;
    state_e         state_q, state_d;
    logic [15:0]    last_conv_q, last_conv_d;
    logic           neg_q, neg_d;
    logic [3:0]     tenths_q, tenths_d;
    logic [8:0]     bin_q, bin_d;
    logic [11:0]    bcd_q, bcd_d;
    logic [3:0]     bit_q, bit_d;
    digits_t        cel_q, cel_d;

    logic [RCW-1:0] ref_q, ref_d;
    logic [1:0]     idx_q, idx_d;
    logic [6:0]     seg_q, seg_d;
    logic           dp_q, dp_d;
    logic [3:0]     an_q, an_d;

    logic [12:0]    t_val;
    logic [12:0]    mag;
    logic [11:0]    bcd_adj;

    always_ff @(posedge clk) begin
        if (reset) begin
            raw_q       <= '0;
            stab_q      <= '0;
            state_q     <= IDLE;
            last_conv_q <= '0;
            neg_q       <= 1'b0;
            tenths_q    <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            bit_q       <= '0;
            cel_q       <= ZERO_DIGITS;
            ref_q       <= '0;
            idx_q       <= '0;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            an_q        <= 4'hF;
        end else begin
            raw_q       <= raw_d;
            stab_q      <= stab_d;
            state_q     <= state_d;
            last_conv_q <= last_conv_d;
            neg_q       <= neg_d;
            tenths_q    <= tenths_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            bit_q       <= bit_d;
            cel_q       <= cel_d;
            ref_q       <= ref_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    always_comb begin
        raw_d = temp_raw;
        if (temp_raw != raw_q) begin
            stab_d = '0;
        end else if (stab_q == STAB_MAX) begin
            stab_d = stab_q;
        end else begin
            stab_d = stab_q + SCW'(1);
        end

        state_d     = state_q;
        last_conv_d = last_conv_q;
        neg_d       = neg_q;
        tenths_d    = tenths_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        bit_d       = bit_q;
        cel_d       = cel_q;

        t_val = last_conv_q[15:3];
        mag   = t_val[12] ? (~t_val + 13'd1) : t_val;

        // Double-dabble add-3 on every BCD digit before the shift.
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (stab_q == STAB_MAX && raw_q != last_conv_q) begin
                    last_conv_d = raw_q;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                neg_d    = t_val[12];
                tenths_d = 4'(({4'b0000, mag[3:0]} * 8'd10) >> 4);
                bin_d    = mag[12:4];
                bcd_d    = '0;
                bit_d    = '0;
                state_d  = CONV;
            end
            CONV: begin
                bcd_d = {bcd_adj[10:0], bin_q[8]};
                bin_d = {bin_q[7:0], 1'b0};
                bit_d = bit_q + 4'd1;
                if (bit_q == 4'd8) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                cel_d   = fmt_celsius(neg_q, bcd_q, tenths_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MINMAX_HOLD_EN
    logic signed [12:0] max_t_q, max_t_d;
    digits_t            max_cel_q, max_cel_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            max_t_q   <= '0;
            max_cel_q <= ZERO_DIGITS;
        end else begin
            max_t_q   <= max_t_d;
            max_cel_q <= max_cel_d;
        end
    end

    always_comb begin
        max_t_d   = max_t_q;
        max_cel_d = max_cel_q;
        if (state_q == DONE && $signed(last_conv_q[15:3]) > max_t_q) begin
            max_t_d   = $signed(last_conv_q[15:3]);
            max_cel_d = cel_d;
        end
    end
`endif

    logic       ref_tick;
    logic [1:0] idx_nx;
    logic [4:0] code;
    logic       dp_sel;
    logic       blank_all;
    logic [6:0] glyph_seg;

    seg7_glyph u_glyph (
        .code (code),
        .seg  (glyph_seg)
    );

    // Outputs are loaded for the next digit on the refresh tick, so an/seg/dp stay aligned.
    always_comb begin
        ref_tick  = (ref_q == REF_LAST);
        ref_d     = ref_tick ? '0 : ref_q + RCW'(1);
        idx_nx    = idx_q + 2'd1;
        idx_d     = ref_tick ? idx_nx : idx_q;

        code      = GLYPH_BLANK;
        dp_sel    = 1'b1;
        blank_all = 1'b0;
        case (sw)
            MODE_CELSIUS: begin
                code   = cel_q[idx_nx];
                dp_sel = (idx_nx != 2'd1);
            end
            MODE_ID: begin
                if (idx_nx == 2'd0) begin
                    code = {1'b0, id[3:0]};
                end else if (idx_nx == 2'd1) begin
                    code = {1'b0, id[7:4]};
                end
            end
            MODE_RAW: begin
                code = {1'b0, last_conv_q[{idx_nx, 2'b00} +: 4]};
            end
            MODE_AUX: begin
`ifdef MINMAX_HOLD_EN
                code   = max_cel_q[idx_nx];
                dp_sel = (idx_nx != 2'd1);
`else
                blank_all = 1'b1;
`endif
            end
            default: blank_all = 1'b1;
        endcase

        seg_d = seg_q;
        dp_d  = dp_q;
        an_d  = an_q;
        if (ref_tick) begin
            seg_d = blank_all ? 7'h7F : glyph_seg;
            dp_d  = blank_all ? 1'b1 : dp_sel;
            an_d  = blank_all ? 4'hF : ~(4'b0001 << idx_nx);
        end
    end

    assign seg  = seg_q;
    assign dp   = dp_q;
    assign an   = an_q;
    assign busy = (state_q != IDLE);

endmodule

// File: doc/temp_display_fmt.md
Name: temp_display_fmt

Overview:
Downstream consumer of the I2C sensor-read master's 16-bit temperature word and 8-bit device ID. Waits for the temperature word to settle, then converts the 13-bit two's-complement Celsius value (0.0625 °C/LSB) to signed decimal. Drives a 4-digit multiplexed active-low 7-segment display. sw selects what is shown.

Parameters:
STABLE_CYCLES, 64, consecutive clk cycles temp_raw must hold one value before conversion starts (rejects partial words while bits shift in)
REFRESH_DIV, 50000, clk cycles each digit stays enabled during multiplexing (≥2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
temp_raw  in  16  sensor word from I2C master; value = temp_raw[15:3], signed, 1/16 °C
id  in  8  sensor ID from I2C master
sw  in  2  display mode select
seg  out  7  segments a..g, active-low
dp  out  1  decimal point, active-low
an  out  4  digit enables, active-low one-hot; an[0] = rightmost digit
busy  out  1  high while a conversion is in progress

Behaviour:
- Reset values: seg=7'h7F, dp=1, an=4'hF, busy=0. last_conv=16'h0000. Converted display value = "  0.0". Stability counter = 0. Refresh counter = 0, digit index = 0.
- Stability detect:
  - Register temp_raw each cycle.
  - Counter clears whenever the registered value changes. Otherwise it increments, saturating at STABLE_CYCLES.
  - Conversion starts when the counter == STABLE_CYCLES, FSM is IDLE, and the registered value != last_conv.
- FSM states and transitions:
  - IDLE → LOAD: 1 cycle; latch value into last_conv; compute sign and magnitude.
  - LOAD → CONV: 9 cycles of iterative double-dabble on the 9-bit integer part.
  - CONV → DONE: 1 cycle; commit digits to the display registers.
  - DONE → IDLE.
  - busy=1 in LOAD, CONV and DONE.
  - New display value is visible on the cycle after DONE: 11 cycles after the start condition.
- Input changes during busy are ignored. The stability counter keeps running, so the start condition re-evaluates in IDLE.
- Arithmetic:
  - t = temp_raw[15:3], 13-bit signed. neg = t[12].
  - mag = neg ? -t : t, 13 bits unsigned; -4096 yields 4096.
  - int = mag[12:4]. tenths = (mag[3:0]*10)>>4, truncating, range 0..9.
- Celsius formatting (sw=00):
  - Digits, left to right: d3 d2 d1 d0.
  - Positive: d3 = hundreds, d2 = tens, d1 = units with dp lit, d0 = tenths.
  - Leading-zero blanking applies to hundreds and tens; units is always shown.
  - Negative: d3 = '-', then tens, units with dp, tenths. Tens is blanked if zero.
  - Negative with int ≥ 100: saturate to "-99.9".
- Other modes:
  - sw=01: d3 and d2 blank; d1 and d0 = id in hex, glyphs 0-9 A b C d E F.
  - sw=10: all four digits = last_conv in hex.
  - sw=11: all segments off and an=4'hF (see Optional Feature).
- Multiplexing:
  - Refresh counter counts 0..REFRESH_DIV-1, then advances the digit index 0→1→2→3→0.
  - an = ~(1<<index).
  - seg and dp are registered from the current mode and index, aligned with an.
- sw changes take effect at the next refresh tick; no conversion is triggered.
- Reset asserted mid-conversion aborts the conversion, returns to IDLE and restores all reset values.

Optional Feature:
MINMAX_HOLD_EN.
- Defined:
  - Tracks the signed maximum of all committed conversions (reset value = the post-reset "0.0" conversion, i.e. t=0).
  - sw=11 shows that maximum, formatted as in sw=00.
- Undefined: sw=11 blanks the display; no max register exists.

Decomposition:
- Package temp_disp_pkg:
  - FSM state enum (IDLE, LOAD, CONV, DONE).
  - Mode constants MODE_CELSIUS, MODE_ID, MODE_RAW, MODE_AUX.
  - Glyph codes GLYPH_BLANK and GLYPH_MINUS (5-bit codes beyond 0-F).
  - Saturation constant for "-99.9".
- Sub-module seg7_glyph: combinational 5-bit glyph code → 7-bit active-low segments; instantiated once after the digit mux.

Test Plan:
- temp_raw=16'h0C80 (25.0), sw=00, held > STABLE_CYCLES → busy for 11 cycles; then digits blank,2,5(dp),0. One-hot an cycles every REFRESH_DIV.
- temp_raw=16'hFAC0 (-10.5) → "-10.5". temp_raw=16'h4B00 (150.0) → "150.0". temp_raw=16'h0010 (0.125) → "  0.1".
- temp_raw=16'h8000 (-256.0) → saturated "-99.9". Without MINMAX_HOLD_EN, sw=11 → an=4'hF.
- temp_raw toggles 16'h0C80/16'h0C88 every STABLE_CYCLES-1 cycles → busy never asserts; display unchanged.
- sw=01, id=8'hCB → d3 and d2 blank, d1='C', d0='b'. sw=10 with last_conv=16'h0C80 → "0C80".
- Reset asserted 4 cycles into CONV → next cycle busy=0, an=4'hF, display "  0.0". A re-held 16'h0C80 reconverts to "25.0".
